// File: rtl/serial_sub8_if.sv
// serial_sub8_if -- request/result bundle for the bit-serial subtractor.
//   start      : request, sampled only while the subtractor is idle
//   a, b       : minuend / subtrahend, captured on the accepting edge
//   busy       : high while bits are being processed
//   done       : one-cycle pulse when a new result is loaded
//   diff       : a - b modulo 2^WIDTH
//   bout       : final borrow (a < b unsigned)
//   ovf        : signed overflow of the subtraction
interface serial_sub8_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;

    modport master (
        output start, a, b,
        input  busy, done, diff, bout, ovf
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, bout, ovf
    );
endinterface

// File: rtl/serial_sub8.sv
// serial_sub8 -- bit-serial subtractor, one bit per clock, LSB first.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : serial_sub8_if slave (start/a/b in, busy/done/diff/bout/ovf out)
//
// state | meaning
// IDLE  | waiting for start; outputs hold the last result
// CALC  | shifting one bit per cycle, WIDTH cycles
// DONE  | result loaded, done pulse; back to IDLE next edge
module serial_sub8 #(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    serial_sub8_if.slave  bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             br_q, br_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic             ovf_q, ovf_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic bit_a, bit_b, d_bit, br_nxt;

    // The shift registers move right, so bit 0 always holds the bit being
    // processed; on the last bit it holds the operand MSBs used for ovf.
    assign bit_a  = a_sh_q[0];
    assign bit_b  = b_sh_q[0];
    assign d_bit  = bit_a ^ bit_b ^ br_q;
    assign br_nxt = (~bit_a & bit_b) | (~bit_a & br_q) | (bit_b & br_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        acc_d   = acc_q;
        br_d    = br_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        ovf_d   = ovf_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_sh_d  = bus.a;
                    b_sh_d  = bus.b;
                    br_d    = 1'b0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = CALC;
                end
            end
            CALC: begin
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                br_d   = br_nxt;
                acc_d  = {d_bit, acc_q[WIDTH-1:1]};
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    diff_d  = {d_bit, acc_q[WIDTH-1:1]};
                    bout_d  = br_nxt;
                    ovf_d   = (bit_a != bit_b) & (d_bit != bit_a);
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            acc_q   <= '0;
            br_q    <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            acc_q   <= acc_d;
            br_q    <= br_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.diff = diff_q;
    assign bus.bout = bout_q;
    assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_serial_sub8.sv
module tb_serial_sub8;
    logic clk;
    logic rst_n;
    int   cyc;
    int   n_vec;
    int   n_err;

    serial_sub8_if #(.WIDTH(8))  if8 ();
    serial_sub8_if #(.WIDTH(16)) if16 ();

    serial_sub8 #(.WIDTH(8))  u_dut8  (.clk(clk), .rst_n(rst_n), .bus(if8));
    serial_sub8 #(.WIDTH(16)) u_dut16 (.clk(clk), .rst_n(rst_n), .bus(if16));

    typedef struct {
        logic [31:0] diff;
        logic        bout;
        logic        ovf;
        int          cyc;
    } exp_t;

    exp_t q8[$];
    exp_t q16[$];
    exp_t e8;
    exp_t e16;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Caller is at a negedge; the following posedge accepts the request.
    task automatic launch8(input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        logic [8:0] r;
        if8.a = a; if8.b = b; if8.start = 1'b1;
        r = {1'b0, a} - {1'b0, b};
        e.diff = 32'(r[7:0]);
        e.bout = r[8];
        e.ovf  = (a[7] != b[7]) && (r[7] != a[7]);
        e.cyc  = cyc + 1 + 8;
        q8.push_back(e);
    endtask

    task automatic launch16(input logic [15:0] a, input logic [15:0] b);
        exp_t e;
        logic [16:0] r;
        if16.a = a; if16.b = b; if16.start = 1'b1;
        r = {1'b0, a} - {1'b0, b};
        e.diff = 32'(r[15:0]);
        e.bout = r[16];
        e.ovf  = (a[15] != b[15]) && (r[15] != a[15]);
        e.cyc  = cyc + 1 + 16;
        q16.push_back(e);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((q8.size() != 0 || q16.size() != 0) && t < 60) begin
            @(negedge clk);
            t++;
        end
        check("drain pending", 32'(q8.size() + q16.size()), 32'd0);
        @(negedge clk);
    endtask

    task automatic op8(input logic [7:0] a, input logic [7:0] b);
        launch8(a, b);
        @(negedge clk);
        if8.start = 1'b0;
        drain();
    endtask

    always @(negedge clk) begin
        if (if8.done) begin
            if (q8.size() == 0) begin
                check("dut8 spurious done", 32'(q8.size()), 32'd1);
            end else begin
                e8 = q8.pop_front();
                check("dut8 latency", 32'(cyc), 32'(e8.cyc));
                check("dut8 diff", 32'(if8.diff), e8.diff);
                check("dut8 bout", 32'(if8.bout), 32'(e8.bout));
                check("dut8 ovf",  32'(if8.ovf),  32'(e8.ovf));
            end
        end
    end

    always @(negedge clk) begin
        if (if16.done) begin
            if (q16.size() == 0) begin
                check("dut16 spurious done", 32'(q16.size()), 32'd1);
            end else begin
                e16 = q16.pop_front();
                check("dut16 latency", 32'(cyc), 32'(e16.cyc));
                check("dut16 diff", 32'(if16.diff), e16.diff);
                check("dut16 bout", 32'(if16.bout), 32'(e16.bout));
                check("dut16 ovf",  32'(if16.ovf),  32'(e16.ovf));
            end
        end
    end

    initial begin
        cyc = 0; n_vec = 0; n_err = 0;
        rst_n = 1'b1;
        if8.start = 1'b0;  if8.a = '0;  if8.b = '0;
        if16.start = 1'b0; if16.a = '0; if16.b = '0;

        // Reset applied before any clock edge: outputs must clear asynchronously.
        #2 rst_n = 1'b0;
        #1;
        check("rst diff",  32'(if8.diff), 32'd0);
        check("rst bout",  32'(if8.bout), 32'd0);
        check("rst ovf",   32'(if8.ovf),  32'd0);
        check("rst busy",  32'(if8.busy), 32'd0);
        check("rst done",  32'(if8.done), 32'd0);
        check("rst busy16", 32'(if16.busy), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed operands, including borrow / overflow / equal corner cases.
        op8(8'd100, 8'd37);
        op8(8'd5,   8'd10);
        op8(8'h80,  8'h01);
        op8(8'h00,  8'h00);
        op8(8'hFF,  8'hFF);
        op8(8'h00,  8'hFF);

        // start held high for 20 cycles: accepts every 10 cycles, start in
        // CALC/DONE ignored, operand changes between accepts have no effect.
        for (int k = 0; k < 20; k++) begin
            if8.start = 1'b1;
            if (k % 10 == 0) begin
                launch8(8'd9, 8'd3);
            end else begin
                if8.a = 8'($urandom);
                if8.b = 8'($urandom);
            end
            @(negedge clk);
            check("hold busy", 32'(if8.busy), ((k % 10) < 8) ? 32'd1 : 32'd0);
            check("hold diff", 32'(if8.diff), (k < 8) ? 32'h01 : 32'h06);
        end
        if8.start = 1'b0;
        drain();

        // Reset during the 4th CALC cycle aborts the operation.
        launch8(8'h30, 8'h10);
        @(negedge clk);
        if8.start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort diff", 32'(if8.diff), 32'd0);
        check("abort bout", 32'(if8.bout), 32'd0);
        check("abort ovf",  32'(if8.ovf),  32'd0);
        check("abort busy", 32'(if8.busy), 32'd0);
        check("abort done", 32'(if8.done), 32'd0);
        q8.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        check("abort no result", 32'(if8.diff), 32'd0);
        op8(8'd7, 8'd2);

        // Random operations on both widths in parallel.
        for (int i = 0; i < 1000; i++) begin
            launch8(8'($urandom), 8'($urandom));
            launch16(16'($urandom), 16'($urandom));
            @(negedge clk);
            if8.start = 1'b0;
            if16.start = 1'b0;
            drain();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/serial_sub8.md
SERIAL_SUB8 -- requirements
Module: serial_sub8

Interface
REQ-001 Parameter: WIDTH, 8, operand and result width in bits (legal range 2..32).
REQ-002 Port: clk  input  1  system clock; all state changes on its rising edge.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: start  input  1  request: subtract b from a; sampled only in IDLE.
REQ-005 Port: a  input  WIDTH  minuend, captured at the accepting edge.
REQ-006 Port: b  input  WIDTH  subtrahend, captured at the accepting edge.
REQ-007 Port: busy  output  1  high while in CALC.
REQ-008 Port: done  output  1  one-cycle pulse marking a new result.
REQ-009 Port: diff  output  WIDTH  result a-b modulo 2^WIDTH; registered.
REQ-010 Port: bout  output  1  final borrow: 1 when a<b (unsigned); registered.
REQ-011 Port: ovf  output  1  signed overflow flag; registered.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, CALC and DONE, all encoded in registers.
REQ-013 IDLE with start=1 at an edge SHALL do the following at that edge: latch a and b into shift registers, clear the borrow flop, clear the bit counter, and go to CALC.
REQ-014 IDLE with start=0 SHALL hold all state and all outputs.
REQ-015 CALC SHALL process one bit per cycle, LSB first, and last exactly WIDTH cycles (bit counter 0..WIDTH-1).
REQ-016 Per bit i: d = a[i]^b[i]^br; br_next = (~a[i]&b[i]) | (~a[i]&br) | (b[i]&br); br starts at 0.
REQ-017 Each d SHALL shift into an internal accumulator MSB-side; after WIDTH shifts, bit i of the accumulator holds d for bit i.
REQ-018 At the edge that processes bit WIDTH-1, the FSM SHALL enter DONE and load outputs: diff <= the final accumulator (including that last bit), bout <= br_next, ovf <= (a[MSB]!=b[MSB]) & (d_MSB!=a[MSB]).
REQ-019 Latency: if start is accepted at edge n, done SHALL be 1 for exactly the cycle after edge n+WIDTH and 0 otherwise.
REQ-020 DONE SHALL last exactly one cycle, then the FSM SHALL return to IDLE unconditionally.
REQ-021 start asserted in CALC or DONE SHALL be ignored, with no queuing and no effect on the result.
REQ-022 start asserted in the first IDLE cycle after DONE SHALL be accepted, giving back-to-back throughput of one operation per WIDTH+2 cycles.
REQ-023 Changes on a and b after the accepting edge SHALL NOT affect the result.
REQ-024 diff, bout and ovf SHALL hold the last completed result until the next DONE; they SHALL NOT change during CALC.
REQ-025 busy SHALL be 1 exactly while the state is CALC.

Reset
REQ-026 rst_n low SHALL immediately, without waiting for a clock edge, force: state IDLE, busy=0, done=0, diff=0, bout=0, ovf=0, and clear the counter, borrow flop and shift registers.
REQ-027 A reset during CALC or DONE SHALL abort the operation: no done pulse, and outputs read 0.
REQ-028 After rst_n deasserts, the first rising edge with start=1 SHALL be accepted normally.

Verification
REQ-029 a=100, b=37, start pulse -> done after 8 cycles; diff=63, bout=0, ovf=0.
REQ-030 a=5, b=10 -> diff=8'hFB, bout=1, ovf=0; a=8'h80, b=8'h01 -> diff=8'h7F, bout=0, ovf=1.
REQ-031 a=0, b=0, then a=8'hFF, b=8'hFF -> diff=0 with bout=0 both times; a=0, b=8'hFF -> diff=8'h01, bout=1.
REQ-032 start held high for 20 cycles with a=9, b=3 -> busy/done pattern repeats every 10 cycles; each result is diff=6; inputs changed mid-CALC have no effect.
REQ-033 rst_n pulsed low during the 4th CALC cycle -> outputs 0 asynchronously, no done pulse; the next start with a=7, b=2 yields diff=5.
REQ-034 Random run with WIDTH=8 and WIDTH=16 (at least 1000 operations each) against the model {bout,diff} = {1'b0,a} - {1'b0,b}, plus the signed-overflow model for ovf -> zero mismatches.
